// File: rtl/spi_txn_engine.sv
// SPI mode-0 transaction engine: one command -> one {rw, addr[9:0], data} frame, MSB first.
// Optional build macro SPI_LOOPBACK_EN adds loopback_en, which samples pico in place of the poci pin.
module spi_txn_engine #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic              start,
  input  logic              read_write,
  input  logic [9:0]        address,
  input  logic [7:0]        data_len,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [DATA_W-1:0] read_data,
  input  logic              poci,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback_en,
`endif
  output logic              pico,
  output logic              cs_b,
  output logic              spi_clk
);

  localparam int FW = DATA_W + 11;
  localparam int BW = $clog2(FW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = ($clog2(DATA_W + 1) > 8) ? $clog2(DATA_W + 1) : 8;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        r_state;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bit;
  logic [BW-1:0]     r_last;
  logic [FW-1:0]     r_frame;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rd;
  logic              r_rw;
  logic              r_sclk;
  logic              r_cs_b;
  logic              r_busy;
  logic              r_done;
  logic              r_len_err;
  logic              r_zpend;

  logic [LW-1:0]     w_len;
  logic [DATA_W-1:0] w_data_al;
  logic              w_accept;
  logic              w_tick;
  logic              w_sample;

  assign w_len    = (int'(data_len) > DATA_W) ? LW'(DATA_W) : LW'(data_len);
  assign w_accept = start & ~r_busy & ~r_zpend;
  assign w_tick   = (r_div == '0);

  // Left-justify the low L payload bits; bits above L-1 shift out of the word.
  always_comb begin
    w_data_al = '0;
    if (!read_write && (w_len != '0))
      w_data_al = write_data << (DATA_W - int'(w_len));
  end

`ifdef SPI_LOOPBACK_EN
  assign w_sample = loopback_en ? pico : poci;
`else
  assign w_sample = poci;
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_last    <= '0;
      r_frame   <= '0;
      r_rx      <= '0;
      r_rd      <= '0;
      r_rw      <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_b    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      r_zpend   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_zpend) begin
        r_zpend   <= 1'b0;
        r_done    <= 1'b1;
        r_len_err <= 1'b1;
      end
      if (r_state != S_IDLE)
        r_div <= w_tick ? DIV_MAX : r_div - DW'(1);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len_err <= 1'b0;
            r_rw      <= read_write;
            if (w_len == '0) begin
              r_zpend <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
              r_cs_b  <= 1'b0;
              r_frame <= {read_write, address, w_data_al};
              r_div   <= DIV_MAX;
              r_bit   <= '0;
              r_last  <= BW'(w_len) + BW'(10);
              r_rx    <= '0;
            end
          end
        end
        S_SHIFT: begin
          if (w_tick) begin
            if (!r_sclk) begin
              r_sclk <= 1'b1;
              // Only data-phase samples enter the result; header bits are dropped.
              if (r_bit >= BW'(11))
                r_rx <= {r_rx[DATA_W-2:0], w_sample};
            end else begin
              r_sclk  <= 1'b0;
              r_frame <= r_frame << 1;
              if (r_bit == r_last)
                r_state <= S_HOLD;
              else
                r_bit <= r_bit + BW'(1);
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            r_cs_b  <= 1'b1;
            r_state <= S_GAP;
            if (r_rw)
              r_rd <= r_rx;
          end
        end
        default: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign len_err   = r_len_err;
  assign read_data = r_rd;
  assign pico      = r_frame[FW-1];
  assign cs_b      = r_cs_b;
  assign spi_clk   = r_sclk;

endmodule
